// File: rtl/parc_mem_arbiter.sv
// parc_mem_arbiter: 2:1 imem/dmem merge onto one memory port, in-order tag FIFO.
// Define PARC_MEM_ARBITER_RR_EN for round-robin ties; default build: dmem wins.

`ifndef VC_MEM_REQ_MSG_SZ
`define VC_MEM_REQ_MSG_SZ(a,d) (1+(a)+$clog2((d)/8)+(d))
`endif
`ifndef VC_MEM_RESP_MSG_SZ
`define VC_MEM_RESP_MSG_SZ(d) (1+$clog2((d)/8)+(d))
`endif

module parc_mem_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic [`VC_MEM_REQ_MSG_SZ(AW,DW)-1:0] imemreq_msg,
  input  logic imemreq_val,
  output logic imemreq_rdy,
  output logic [`VC_MEM_RESP_MSG_SZ(DW)-1:0] imemresp_msg,
  output logic imemresp_val,
  input  logic [`VC_MEM_REQ_MSG_SZ(AW,DW)-1:0] dmemreq_msg,
  input  logic dmemreq_val,
  output logic dmemreq_rdy,
  output logic [`VC_MEM_RESP_MSG_SZ(DW)-1:0] dmemresp_msg,
  output logic dmemresp_val,
  output logic [`VC_MEM_REQ_MSG_SZ(AW,DW)-1:0] memreq_msg,
  output logic memreq_val,
  input  logic memreq_rdy,
  input  logic [`VC_MEM_RESP_MSG_SZ(DW)-1:0] memresp_msg,
  input  logic memresp_val,
  output logic err_orphan
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] tags;
  logic [PW-1:0]    hd;
  logic [PW-1:0]    tl;
  logic [CW-1:0]    cnt;
  logic lock;
  logic lock_src;
  logic gnt;
  logic gnt_val;
  logic tie;
  logic space;
  logic push;
  logic pop;
  logic head;
  logic orphan;
  logic err_q;

`ifdef PARC_MEM_ARBITER_RR_EN
  logic pri;
  assign tie = pri;
`else
  assign tie = 1'b1;
`endif

  // grant select: held grant first, then single requester, then tie-break
  always_comb begin
    gnt = 1'b0;
    priority case (1'b1)
      lock:                       gnt = lock_src;
      imemreq_val && dmemreq_val: gnt = tie;
      dmemreq_val:                gnt = 1'b1;
      default:                    gnt = 1'b0;
    endcase
  end

  assign head    = tags[hd];
  assign pop     = reset & memresp_val & (cnt != '0);
  assign orphan  = reset & memresp_val & (cnt == '0);
  assign space   = (cnt != CW'(DEPTH)) | pop;
  assign gnt_val = gnt ? dmemreq_val : imemreq_val;

  assign memreq_val  = reset & gnt_val & space;
  assign memreq_msg  = gnt ? dmemreq_msg : imemreq_msg;
  assign push        = memreq_val & memreq_rdy;
  assign imemreq_rdy = reset & ~gnt & memreq_rdy & space;
  assign dmemreq_rdy = reset & gnt & memreq_rdy & space;

  assign imemresp_val = pop & ~head;
  assign dmemresp_val = pop & head;
  assign imemresp_msg = memresp_msg;
  assign dmemresp_msg = memresp_msg;
  assign err_orphan   = err_q;

  // tag FIFO: push source on fire, pop head on each routed response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags <= '0;
      hd   <= '0;
      tl   <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        tags[tl] <= gnt;
        tl       <= tl + PW'(1);
      end
      if (pop) hd <= hd + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // hold the grant while memory stalls an offered request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock     <= 1'b0;
      lock_src <= 1'b0;
    end else if (push) begin
      lock <= 1'b0;
    end else if (memreq_val) begin
      lock     <= 1'b1;
      lock_src <= gnt;
    end
  end

`ifdef PARC_MEM_ARBITER_RR_EN
  // round-robin: the loser of each fire is preferred next time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    pri <= 1'b0;
    else if (push) pri <= ~gnt;
  end
`endif

  // sticky orphan-response flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      err_q <= 1'b0;
    else if (orphan) err_q <= 1'b1;
  end

endmodule

// File: doc/parc_mem_arbiter.md
# parc_mem_arbiter

Two-to-one memory-port arbiter sitting directly downstream of the 5-stage PARCv2 core. It merges the core's instruction and data request/response ports onto one shared memory port. Each accepted request is tagged with its source in an in-order tag FIFO, and each memory response is routed back to the matching source. The memory returns responses in request order, and the core's response ports have no ready, so responses are always delivered on the same cycle they arrive.

## Interface
Parameters:
- `DEPTH`, 4: maximum outstanding requests (tag FIFO entries); power of two, 2..16.
- `AW`, 32: address width of request messages.
- `DW`, 32: data width of request and response messages.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `imemreq_msg`  in  `VC_MEM_REQ_MSG_SZ(AW,DW)`  instruction request from the core.
- `imemreq_val`  in  1  instruction request valid.
- `imemreq_rdy`  out  1  instruction request accepted.
- `imemresp_msg`  out  `VC_MEM_RESP_MSG_SZ(DW)`  instruction response.
- `imemresp_val`  out  1  instruction response valid.
- `dmemreq_msg`  in  `VC_MEM_REQ_MSG_SZ(AW,DW)`  data request from the core.
- `dmemreq_val`  in  1  data request valid.
- `dmemreq_rdy`  out  1  data request accepted.
- `dmemresp_msg`  out  `VC_MEM_RESP_MSG_SZ(DW)`  data response.
- `dmemresp_val`  out  1  data response valid.
- `memreq_msg`  out  `VC_MEM_REQ_MSG_SZ(AW,DW)`  merged request to memory.
- `memreq_val`  out  1  merged request valid.
- `memreq_rdy`  in  1  memory accepts the request.
- `memresp_msg`  in  `VC_MEM_RESP_MSG_SZ(DW)`  memory response, returned in order.
- `memresp_val`  in  1  memory response valid; there is no ready.
- `err_orphan`  out  1  sticky flag: a response arrived with no request outstanding.

## Operation
State:
- tag FIFO (`DEPTH` x 1 bit; 0 = imem, 1 = dmem), with head/tail pointers and a count.
- `pri`: 1-bit priority pointer, 0 = imem preferred.
- `lock` and `lock_src`: hold the current grant.
- `err_orphan` flag.

Arbitration:
- `space` = count < `DEPTH`, or a pop occurs this cycle.
- If `lock` is set, the grant goes to `lock_src`.
- Otherwise, if only one source is valid, it is granted.
- Otherwise, if both are valid, `pri` selects the winner.

Request path (combinational):
- `memreq_val` = granted source's val & `space`.
- `memreq_msg` = granted source's msg, forwarded unmodified.
- Granted source's rdy = `memreq_rdy` & `space`; the other source's rdy = 0.

Fire (`memreq_val` & `memreq_rdy`):
- push the source tag.
- clear `lock`.
- under round-robin, set `pri` to the non-granted source.

Lock rule:
- If `memreq_val` & !`memreq_rdy`, set `lock` and `lock_src` to the granted source.
- The grant never switches mid-handshake.

Response path:
- On `memresp_val` with count > 0: pop the head.
  - head = 0: `imemresp_val` = 1, `imemresp_msg` = `memresp_msg`.
  - head = 1: the same on the dmem side.
- The non-selected response val is 0.
- On `memresp_val` with count = 0: no output val, no pop, set `err_orphan`. It is cleared only by reset.

Push and pop in the same cycle:
- count is unchanged; both pointers advance, wrapping modulo `DEPTH`.
- Allowed when full: the pop frees the entry that the push uses.

## Timing
- Request forwarding has zero-cycle latency: core val to `memreq_val` is combinational.
- Response routing has zero-cycle latency: `memresp_val` to `imemresp_val` / `dmemresp_val` is combinational.
- Reset (asserted asynchronously, removed synchronously to `clk`): count = 0, pointers = 0, `pri` = 0, `lock` = 0, `err_orphan` = 0.
- Outputs while in reset: `memreq_val` = 0, both response vals = 0, both rdys = 0.
- Reset mid-operation discards outstanding tags; responses arriving afterwards set `err_orphan`.
- Full (count = `DEPTH`, no pop this cycle): both rdys = 0, `memreq_val` = 0. Requesters hold val; `lock` is not set.
- A response arriving in the same cycle as the FIFO's first push (count = 0) is an orphan; the push still completes.

## Configuration
- `PARC_MEM_ARBITER_RR_EN`
  - Defined: round-robin, with `pri` updated on every fire as above.
  - Undefined: fixed priority, dmem always wins ties; the `pri` register is removed.
- Lock and FIFO behaviour are identical in both builds.

## Test plan
- Single imem read to 0x1000, memory ready, response data 0xDEADBEEF next cycle -> `imemreq_rdy` = 1 on the same cycle; `imemresp_val` = 1 with data 0xDEADBEEF; `dmemresp_val` stays 0.
- Both valid every cycle, `memreq_rdy` = 1, RR build -> grants alternate imem, dmem, imem, dmem. Fixed build -> dmem is granted 4 times in a row.
- Both valid, `memreq_rdy` held 0 for 3 cycles then 1 -> `memreq_msg` is stable at the first winner for all 4 cycles; only that source sees rdy = 1.
- `DEPTH` = 4: issue 4 requests without responses -> 5th request sees rdy = 0. Then a response plus a new request in the same cycle -> both complete; count stays 4.
- Interleaved sequence I, D, D, I with in-order responses 0x11, 0x22, 0x33, 0x44 -> imem receives 0x11 then 0x44; dmem receives 0x22 then 0x33.
- `memresp_val` pulse with no outstanding request -> `err_orphan` = 1 and stays 1; no response val is asserted. Asserting `reset` low clears it.
